// File: rtl/uop_dispatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uop_dispatch_ctrl_pkg
// Shared types for the uop queue / dispatch slice.
//   OUT_UOP    : lanes per dispatch bundle
//   QU_UOP     : uop queue depth
//   uop_ins_t  : one decoded uop
//   uop_size_t : queue occupancy / lane count (holds 0..QU_UOP)
//   credit_t   : backend credit counter, CRED_W bits wide
//   dispatch_state_e : dispatch controller FSM states
// -----------------------------------------------------------------------------
package uop_dispatch_ctrl_pkg;

    localparam int OUT_UOP    = 4;
    localparam int QU_UOP     = 16;
    localparam int UOP_W      = 32;
    localparam int UOP_SIZE_W = $clog2(QU_UOP + 1);
    localparam int CRED_W     = 5;

    typedef logic [UOP_W-1:0]      uop_ins_t;
    typedef logic [UOP_SIZE_W-1:0] uop_size_t;
    typedef logic [CRED_W-1:0]     credit_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        STALL    = 2'd2,
        FLUSH    = 2'd3
    } dispatch_state_e;

    // Number of lanes a bundle carries: min(occupancy, OUT_UOP).
    function automatic uop_size_t issue_width(input uop_size_t occ);
        if (occ > uop_size_t'(OUT_UOP)) begin
            return uop_size_t'(OUT_UOP);
        end else begin
            return occ;
        end
    endfunction

endpackage

// File: rtl/uop_credit_counter.sv
// -----------------------------------------------------------------------------
// uop_credit_counter
// Tracks free backend reservation slots. Each cycle the count is charged by
// the number of uops actually issued and refunded by the backend's returns;
// both apply in the same cycle. Results above CREDITS are clamped and flagged.
//   clk, reset           : clock, synchronous active-high reset
//   issue_n_i            : uops issued this cycle (0 when not issuing)
//   credit_ret_i         : slots freed by the backend this cycle
//   credits_o            : current credit count (registered)
//   can_reserve_o        : current credits >= OUT_UOP
//   next_can_reserve_o   : next-cycle credits >= OUT_UOP
//   full_o               : current credits == CREDITS (backend fully drained)
//   overflow_o           : this cycle's update exceeded CREDITS and was clamped
// -----------------------------------------------------------------------------
module uop_credit_counter
    import uop_dispatch_ctrl_pkg::*;
#(
    parameter int CREDITS = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  uop_size_t issue_n_i,
    input  credit_t   credit_ret_i,
    output credit_t   credits_o,
    output logic      can_reserve_o,
    output logic      next_can_reserve_o,
    output logic      full_o,
    output logic      overflow_o
);

    // Two spare bits so the add cannot wrap before the clamp compare.
    localparam int SUM_W = CRED_W + 2;
    typedef logic [SUM_W-1:0] sum_t;

    credit_t credits_q;
    credit_t credits_d;
    sum_t    add_s;
    sum_t    sub_s;

    // Next credit value: add returns, subtract issued uops, clamp to CREDITS.
    always_comb begin
        add_s      = sum_t'(credits_q) + sum_t'(credit_ret_i);
        sub_s      = sum_t'(issue_n_i);
        overflow_o = 1'b0;
        if (add_s < sub_s) begin
            // Unreachable while issue requires credits >= OUT_UOP; floor at 0
            // rather than wrapping to a huge count.
            credits_d = '0;
        end else if ((add_s - sub_s) > sum_t'(CREDITS)) begin
            credits_d  = credit_t'(CREDITS);
            overflow_o = 1'b1;
        end else begin
            credits_d = credit_t'(add_s - sub_s);
        end
    end

    // Credit register; reset restores the full pool.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q <= credit_t'(CREDITS);
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits_o          = credits_q;
    assign can_reserve_o      = (credits_q >= credit_t'(OUT_UOP));
    assign next_can_reserve_o = (credits_d >= credit_t'(OUT_UOP));
    assign full_o             = (credits_q == credit_t'(CREDITS));

endmodule

// File: rtl/uop_credit_overflow_chk.sv
// -----------------------------------------------------------------------------
// uop_credit_overflow_chk
// Simulation-only checker: reports whenever the backend returns more credits
// than the pool can hold (the counter clamps, but the backend is misbehaving).
//   clk, reset  : clock, synchronous active-high reset
//   overflow_i  : clamp flag from uop_credit_counter
// -----------------------------------------------------------------------------
module uop_credit_overflow_chk (
    input logic clk,
    input logic reset,
    input logic overflow_i
);

    // Flag every clamped credit update outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            a_no_credit_overflow : assert (!overflow_i)
                else $warning("credit return exceeded pool size; count clamped");
        end
    end

endmodule

// File: rtl/uop_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// uop_dispatch_ctrl
// Pops uop bundles from the uop queue into the backend while credits allow,
// registers the dispatched bundle, handles pipeline flush (queue clear then
// drain wait) and counts stall cycles.
//   clk, reset      : clock, synchronous active-high reset
//   q_elements      : uop queue occupancy
//   q_uop           : queue output bundle, valid while get_uop=1
//   get_uop         : pop request to the queue (combinational)
//   q_clear         : one-cycle pulse telling the queue to reset head/tail
//   dispatch_valid  : registered; dispatch_uop/dispatch_cnt valid
//   dispatch_uop    : registered bundle, lanes >= dispatch_cnt are zero
//   dispatch_cnt    : valid lanes in the bundle, 1..OUT_UOP
//   credit_ret      : slots freed by the backend this cycle
//   flush           : flush request (level or pulse)
//   flush_done      : one-cycle pulse when the backend has fully drained
//   stall_cnt       : saturating count of cycles spent in STALL
// -----------------------------------------------------------------------------
module uop_dispatch_ctrl
    import uop_dispatch_ctrl_pkg::*;
#(
    parameter int CREDITS = 16,
    parameter int STALL_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  uop_size_t                  q_elements,
    input  uop_ins_t [OUT_UOP-1:0]     q_uop,
    output logic                       get_uop,
    output logic                       q_clear,
    output logic                       dispatch_valid,
    output uop_ins_t [OUT_UOP-1:0]     dispatch_uop,
    output uop_size_t                  dispatch_cnt,
    input  credit_t                    credit_ret,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [STALL_W-1:0]         stall_cnt
);

    dispatch_state_e          state_q, state_d;
    logic                     flush_q;
    logic                     dispatch_valid_q, dispatch_valid_d;
    uop_ins_t [OUT_UOP-1:0]   dispatch_uop_q, dispatch_uop_d;
    uop_size_t                dispatch_cnt_q, dispatch_cnt_d;
    logic [STALL_W-1:0]       stall_cnt_q, stall_cnt_d;

    uop_size_t                issue_width_s;
    uop_size_t                issue_n_s;
    logic                     can_issue_s;
    logic                     q_clear_s;
    logic                     flush_done_s;
    credit_t                  credits_s;
    logic                     can_reserve_s;
    logic                     next_can_reserve_s;
    logic                     credits_full_s;
    logic                     overflow_s;

    assign issue_width_s = issue_width(q_elements);
    // Credits are checked as a full OUT_UOP block but charged per uop issued.
    assign issue_n_s     = can_issue_s ? issue_width_s : uop_size_t'(0);

    uop_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk                (clk),
        .reset              (reset),
        .issue_n_i          (issue_n_s),
        .credit_ret_i       (credit_ret),
        .credits_o          (credits_s),
        .can_reserve_o      (can_reserve_s),
        .next_can_reserve_o (next_can_reserve_s),
        .full_o             (credits_full_s),
        .overflow_o         (overflow_s)
    );

    // FSM next state plus the combinational pop / clear / done strobes.
    always_comb begin
        state_d      = state_q;
        q_clear_s    = 1'b0;
        flush_done_s = 1'b0;
        can_issue_s  = ((state_q == IDLE) || (state_q == DISPATCH)) &&
                       (q_elements != '0) && can_reserve_s && !flush && !reset;
        case (state_q)
            IDLE: begin
                if (q_elements != '0) begin
                    state_d = DISPATCH;
                end else begin
                    state_d = IDLE;
                end
            end
            DISPATCH: begin
                if (q_elements == '0) begin
                    state_d = IDLE;
                end else if (!can_reserve_s) begin
                    state_d = STALL;
                end else begin
                    state_d = DISPATCH;
                end
            end
            STALL: begin
                if (next_can_reserve_s) begin
                    state_d = DISPATCH;
                end else begin
                    state_d = STALL;
                end
            end
            FLUSH: begin
                // Leave only once the backend has returned every slot and
                // the flush request has dropped.
                if (credits_full_s && !flush) begin
                    state_d      = IDLE;
                    flush_done_s = !reset;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flush overrides every state; q_clear fires on entry and on each
        // fresh rising edge of flush while already flushing.
        if (flush) begin
            state_d   = FLUSH;
            q_clear_s = ((state_q != FLUSH) || !flush_q) && !reset;
        end else begin
            q_clear_s = 1'b0;
        end
    end

    // Dispatch bundle capture (unused lanes zeroed) and stall counter update.
    always_comb begin
        dispatch_valid_d = can_issue_s;
        dispatch_uop_d   = dispatch_uop_q;
        dispatch_cnt_d   = dispatch_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        if (can_issue_s) begin
            dispatch_cnt_d = issue_width_s;
            for (int i = 0; i < OUT_UOP; i++) begin
                if (uop_size_t'(i) < issue_width_s) begin
                    dispatch_uop_d[i] = q_uop[i];
                end else begin
                    dispatch_uop_d[i] = '0;
                end
            end
        end else begin
            dispatch_cnt_d = dispatch_cnt_q;
        end
        if ((state_q == STALL) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, flush history, dispatch output and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            flush_q          <= 1'b0;
            dispatch_valid_q <= 1'b0;
            dispatch_uop_q   <= '0;
            dispatch_cnt_q   <= '0;
            stall_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            flush_q          <= flush;
            dispatch_valid_q <= dispatch_valid_d;
            dispatch_uop_q   <= dispatch_uop_d;
            dispatch_cnt_q   <= dispatch_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign get_uop        = can_issue_s;
    assign q_clear        = q_clear_s;
    assign flush_done     = flush_done_s;
    assign dispatch_valid = dispatch_valid_q;
    assign dispatch_uop   = dispatch_uop_q;
    assign dispatch_cnt   = dispatch_cnt_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_uop_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uop_dispatch_ctrl
// Directed scenarios for uop_dispatch_ctrl with hand-computed expectations
// (CREDITS=16, OUT_UOP=4). Inputs change 1 time unit after the rising edge;
// outputs are compared 2 units later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_uop_dispatch_ctrl;
    import uop_dispatch_ctrl_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    uop_size_t              q_elements;
    uop_ins_t [OUT_UOP-1:0] q_uop;
    logic                   get_uop;
    logic                   q_clear;
    logic                   dispatch_valid;
    uop_ins_t [OUT_UOP-1:0] dispatch_uop;
    uop_size_t              dispatch_cnt;
    credit_t                credit_ret;
    logic                   flush;
    logic                   flush_done;
    logic [15:0]            stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    uop_ins_t [OUT_UOP-1:0] exp_uop;

    always #5 clk = ~clk;

    uop_dispatch_ctrl #(.CREDITS(16), .STALL_W(16)) dut (
        .clk(clk), .reset(reset), .q_elements(q_elements), .q_uop(q_uop),
        .get_uop(get_uop), .q_clear(q_clear), .dispatch_valid(dispatch_valid),
        .dispatch_uop(dispatch_uop), .dispatch_cnt(dispatch_cnt),
        .credit_ret(credit_ret), .flush(flush), .flush_done(flush_done),
        .stall_cnt(stall_cnt)
    );

    uop_credit_overflow_chk u_chk (
        .clk(clk), .reset(reset), .overflow_i(dut.u_credit.overflow_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [31:0] base);
        for (int i = 0; i < OUT_UOP; i++) q_uop[i] = base + 32'(i);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; q_elements = '0; credit_ret = '0; set_bundle(32'h5555_0000);
        tick(); tick(); #2;
        n_checks++; if (dispatch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %0b want 0", dispatch_valid); end
        n_checks++; if (dispatch_uop !== '0) begin n_fail++; $display("FAIL rst_uop: got %0h want 0", dispatch_uop); end
        n_checks++; if (dispatch_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", dispatch_cnt); end
        n_checks++; if ({get_uop, q_clear, flush_done} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {get_uop, q_clear, flush_done}); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
        n_checks++; if (dut.u_credit.credits_o !== 5'd16) begin n_fail++; $display("FAIL rst_credits: got %0d want 16", dut.u_credit.credits_o); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want IDLE", dut.state_q); end
        reset = 1'b0;
    endtask

    // q_elements=6: bundles of 4 then 2, credits 16 -> 12 -> 10.
    task automatic test_basic();
        q_elements = 5'd6; set_bundle(32'hA000_0000); #2;
        n_checks++; if (get_uop !== 1'b1) begin n_fail++; $display("FAIL basic_get1: got %0b want 1", get_uop); end
        tick();
        q_elements = 5'd2; set_bundle(32'hB000_0000); #2;
        for (int i = 0; i < OUT_UOP; i++) exp_uop[i] = 32'hA000_0000 + 32'(i);
        n_checks++; if (get_uop !== 1'b1) begin n_fail++; $display("FAIL basic_get2: got %0b want 1", get_uop); end
        n_checks++; if ({dispatch_valid, dispatch_cnt} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL basic_disp1: got v=%0b n=%0d want v=1 n=4", dispatch_valid, dispatch_cnt); end
        n_checks++; if (dispatch_uop !== exp_uop) begin n_fail++; $display("FAIL basic_uop1: got %0h want %0h", dispatch_uop, exp_uop); end
        n_checks++; if (dut.u_credit.credits_o !== 5'd12) begin n_fail++; $display("FAIL basic_cred12: got %0d want 12", dut.u_credit.credits_o); end
        tick();
        q_elements = 5'd0; #2;
        exp_uop = '0; exp_uop[0] = 32'hB000_0000; exp_uop[1] = 32'hB000_0001;
        n_checks++; if (get_uop !== 1'b0) begin n_fail++; $display("FAIL basic_get3: got %0b want 0", get_uop); end
        n_checks++; if ({dispatch_valid, dispatch_cnt} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL basic_disp2: got v=%0b n=%0d want v=1 n=2", dispatch_valid, dispatch_cnt); end
        n_checks++; if (dispatch_uop !== exp_uop) begin n_fail++; $display("FAIL basic_uop2_zero_lanes: got %0h want %0h", dispatch_uop, exp_uop); end
        n_checks++; if (dut.u_credit.credits_o !== 5'd10) begin n_fail++; $display("FAIL basic_cred10: got %0d want 10", dut.u_credit.credits_o); end
        tick();
        credit_ret = 5'd6; #2;
        n_checks++; if (dispatch_valid !== 1'b0) begin n_fail++; $display("FAIL basic_dv_once: got %0b want 0", dispatch_valid); end
        tick();
        credit_ret = 5'd0;
    endtask

    // q_elements=3: credits 16,13,10,7,4 -> 1, then STALL until credit_ret=3.
    task automatic test_stall();
        q_elements = 5'd3; set_bundle(32'hC000_0000);
        for (int k = 0; k < 5; k++) begin
            #2;
            n_checks++; if ({get_uop, dut.u_credit.credits_o} !== {1'b1, credit_t'(16 - 3 * k)}) begin n_fail++; $display("FAIL stall_issue%0d: got get=%0b cred=%0d want get=1 cred=%0d", k, get_uop, dut.u_credit.credits_o, 16 - 3 * k); end
            tick();
        end
        #2;
        n_checks++; if ({get_uop, dut.u_credit.credits_o, dispatch_cnt} !== {1'b0, 5'd1, 5'd3}) begin n_fail++; $display("FAIL stall_low: got get=%0b cred=%0d n=%0d want get=0 cred=1 n=3", get_uop, dut.u_credit.credits_o, dispatch_cnt); end
        tick(); #2;
        n_checks++; if ({dut.state_q, get_uop, stall_cnt} !== {STALL, 1'b0, 16'd0}) begin n_fail++; $display("FAIL stall_enter: got st=%0d get=%0b cnt=%0d want st=2 get=0 cnt=0", dut.state_q, get_uop, stall_cnt); end
        tick(); #2;
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_cnt1: got %0d want 1", stall_cnt); end
        tick();
        credit_ret = 5'd3; #2;
        n_checks++; if ({get_uop, stall_cnt} !== {1'b0, 16'd2}) begin n_fail++; $display("FAIL stall_ret: got get=%0b cnt=%0d want get=0 cnt=2", get_uop, stall_cnt); end
        tick();
        credit_ret = 5'd0; #2;
        n_checks++; if ({dut.state_q, get_uop, dut.u_credit.credits_o, stall_cnt} !== {DISPATCH, 1'b1, 5'd4, 16'd3}) begin n_fail++; $display("FAIL stall_resume: got st=%0d get=%0b cred=%0d cnt=%0d want st=1 get=1 cred=4 cnt=3", dut.state_q, get_uop, dut.u_credit.credits_o, stall_cnt); end
        tick();
        q_elements = 5'd0; credit_ret = 5'd3;
        tick();
        credit_ret = 5'd0;
    endtask

    // credits=4: issue 4 and return 4 in the same cycle, back to back.
    task automatic test_back_to_back();
        q_elements = 5'd8; credit_ret = 5'd4; set_bundle(32'hD000_0000);
        for (int k = 0; k < 3; k++) begin
            #2;
            n_checks++; if ({get_uop, dut.u_credit.credits_o} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL b2b_issue%0d: got get=%0b cred=%0d want get=1 cred=4", k, get_uop, dut.u_credit.credits_o); end
            if (k > 0) begin
                n_checks++; if ({dispatch_valid, dispatch_cnt} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL b2b_disp%0d: got v=%0b n=%0d want v=1 n=4", k, dispatch_valid, dispatch_cnt); end
            end
            tick();
        end
    endtask

    // Flush from DISPATCH with credits=8, re-pulse on a new rising edge,
    // then a flush from IDLE with a full pool.
    task automatic test_flush();
        q_elements = 5'd0; credit_ret = 5'd4; tick();
        q_elements = 5'd4; credit_ret = 5'd4; tick();
        flush = 1'b1; credit_ret = 5'd0; #2;
        n_checks++; if ({dut.state_q, dut.u_credit.credits_o} !== {DISPATCH, 5'd8}) begin n_fail++; $display("FAIL flush_setup: got st=%0d cred=%0d want st=1 cred=8", dut.state_q, dut.u_credit.credits_o); end
        n_checks++; if ({q_clear, get_uop, dispatch_valid} !== 3'b101) begin n_fail++; $display("FAIL flush_entry: got clr/get/dv=%b want 101", {q_clear, get_uop, dispatch_valid}); end
        tick();
        q_elements = 5'd0; credit_ret = 5'd3; #2;
        n_checks++; if ({q_clear, flush_done, dispatch_valid, dut.state_q} !== {3'b000, FLUSH}) begin n_fail++; $display("FAIL flush_held: got clr/done/dv=%b st=%0d want 000 st=3", {q_clear, flush_done, dispatch_valid}, dut.state_q); end
        tick();
        flush = 1'b0; credit_ret = 5'd0; #2;
        n_checks++; if ({q_clear, flush_done, dut.u_credit.credits_o} !== {2'b00, 5'd11}) begin n_fail++; $display("FAIL flush_drain: got clr/done=%b cred=%0d want 00 cred=11", {q_clear, flush_done}, dut.u_credit.credits_o); end
        tick();
        flush = 1'b1; credit_ret = 5'd5; #2;
        n_checks++; if ({q_clear, flush_done} !== 2'b10) begin n_fail++; $display("FAIL flush_repulse: got clr/done=%b want 10", {q_clear, flush_done}); end
        tick();
        flush = 1'b0; credit_ret = 5'd0; #2;
        n_checks++; if ({flush_done, q_clear, dut.u_credit.credits_o} !== {2'b10, 5'd16}) begin n_fail++; $display("FAIL flush_done: got done/clr=%b cred=%0d want 10 cred=16", {flush_done, q_clear}, dut.u_credit.credits_o); end
        tick(); #2;
        n_checks++; if ({flush_done, dut.state_q} !== {1'b0, IDLE}) begin n_fail++; $display("FAIL flush_idle: got done=%0b st=%0d want done=0 st=0", flush_done, dut.state_q); end
        tick();
        flush = 1'b1; #2;
        n_checks++; if ({q_clear, get_uop, flush_done} !== 3'b100) begin n_fail++; $display("FAIL idle_flush_entry: got clr/get/done=%b want 100", {q_clear, get_uop, flush_done}); end
        tick();
        flush = 1'b0; #2;
        n_checks++; if ({flush_done, q_clear} !== 2'b10) begin n_fail++; $display("FAIL idle_flush_done: got done/clr=%b want 10", {flush_done, q_clear}); end
        tick(); #2;
        n_checks++; if ({flush_done, dut.state_q} !== {1'b0, IDLE}) begin n_fail++; $display("FAIL idle_flush_back: got done=%0b st=%0d want done=0 st=0", flush_done, dut.state_q); end
        tick();
    endtask

    // Reset while in FLUSH aborts it: reset values return, no flush_done.
    task automatic test_reset_in_flush();
        q_elements = 5'd4; set_bundle(32'hE000_0000); tick();
        q_elements = 5'd0; flush = 1'b1; #2;
        n_checks++; if (q_clear !== 1'b1) begin n_fail++; $display("FAIL rif_clear: got %0b want 1", q_clear); end
        tick();
        flush = 1'b0; reset = 1'b1; credit_ret = 5'd4; #2;
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rif_done_in_reset: got %0b want 0", flush_done); end
        tick();
        reset = 1'b0; credit_ret = 5'd0; #2;
        n_checks++; if ({dispatch_valid, dispatch_cnt, dispatch_uop} !== '0) begin n_fail++; $display("FAIL rif_disp: got v=%0b n=%0d uop=%0h want all 0", dispatch_valid, dispatch_cnt, dispatch_uop); end
        n_checks++; if ({dut.state_q, dut.u_credit.credits_o, stall_cnt} !== {IDLE, 5'd16, 16'd0}) begin n_fail++; $display("FAIL rif_state: got st=%0d cred=%0d stall=%0d want st=0 cred=16 stall=0", dut.state_q, dut.u_credit.credits_o, stall_cnt); end
        n_checks++; if ({get_uop, q_clear, flush_done} !== 3'b000) begin n_fail++; $display("FAIL rif_strobes: got %b want 000", {get_uop, q_clear, flush_done}); end
        tick(); #2;
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rif_no_done: got %0b want 0", flush_done); end
        tick();
    endtask

    // Returning credits into a full pool clamps at 16 and raises the flag.
    task automatic test_overflow();
        credit_ret = 5'd2; #2;
        n_checks++; if (dut.u_credit.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", dut.u_credit.overflow_o); end
        tick();
        credit_ret = 5'd0; #2;
        n_checks++; if ({dut.u_credit.credits_o, dut.u_credit.overflow_o} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL ovf_clamp: got cred=%0d flag=%0b want cred=16 flag=0", dut.u_credit.credits_o, dut.u_credit.overflow_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_in_flush();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uop_dispatch_ctrl.md
Name: uop_dispatch_ctrl

Overview:
- Sequences uop issue from the uop queue into the backend reservation stations.
- Drives the queue's get_uop from queue occupancy and a backend credit counter (free reservation slots).
- Registers the dispatched uop bundle, handles pipeline flush (queue clear, then drain wait), and counts stall cycles for perf monitoring.

Parameters:
- CREDITS, 16, backend reservation slots; initial and maximum credit count.
- CRED_W, 5, credit counter width; must hold CREDITS.
- STALL_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- q_elements  in  uop_size_t  current uop queue occupancy
- q_uop  in  uop_ins_t[OUT_UOP-1:0]  queue output bundle, valid combinationally while get_uop=1
- get_uop  out  1  pop request to the queue (combinational)
- q_clear  out  1  one-cycle pulse; queue owner resets head/tail
- dispatch_valid  out  1  registered; dispatch_uop/dispatch_cnt are valid
- dispatch_uop  out  uop_ins_t[OUT_UOP-1:0]  registered uop bundle
- dispatch_cnt  out  uop_size_t  number of valid lanes, 1..OUT_UOP
- credit_ret  in  CRED_W  slots freed by the backend this cycle
- flush  in  1  pipeline flush request (level or pulse)
- flush_done  out  1  one-cycle pulse when the flush completes
- stall_cnt  out  STALL_W  saturating count of STALL cycles

Behaviour:
- Reset values:
  - state=IDLE, credits=CREDITS.
  - dispatch_valid=0, dispatch_uop=0, dispatch_cnt=0.
  - get_uop=0, q_clear=0, flush_done=0, stall_cnt=0.
- Reset has priority over everything. Reset mid-flush aborts the flush; no flush_done is issued.
- Issue condition `can_issue`: state is IDLE/DISPATCH, q_elements>0, credits>=OUT_UOP, and flush=0.
- get_uop equals can_issue.
- Issue width: n = min(q_elements, OUT_UOP).
- On an issue cycle:
  - dispatch_uop <= q_uop and dispatch_cnt <= n on the next edge.
  - dispatch_valid=1 for exactly one cycle per issue.
  - Latency is 1 cycle from get_uop to dispatch_valid.
- Lanes >= n of dispatch_uop are zeroed.
- Credits update each cycle: credits_next = credits - (issue ? n : 0) + credit_ret.
  - Both terms apply in the same cycle.
  - If the result exceeds CREDITS, clamp to CREDITS and fire a simulation assertion.
- Credits are reserved as a full OUT_UOP block (issue test) but charged per issued uop (n). Partial bundles do not leak credits.
- State machine:
  - IDLE: q_elements=0. Go to DISPATCH when q_elements>0.
  - DISPATCH:
    - Go to STALL if q_elements>0 and credits<OUT_UOP.
    - Go to IDLE if q_elements=0.
  - STALL: get_uop=0. stall_cnt increments each cycle, saturating at all-ones. Go to DISPATCH when credits_next>=OUT_UOP.
  - FLUSH:
    - Entered from any state when flush=1.
    - On the entry cycle, q_clear=1 for one cycle and get_uop is forced 0, even if can_issue would hold.
    - Stay in FLUSH while credits<CREDITS (backend draining); credit_ret is still accepted.
    - When credits==CREDITS and flush=0: pulse flush_done and go to IDLE.
    - flush held high keeps the block in FLUSH. No q_clear re-pulse while flush remains high.
    - A new rising edge of flush while in FLUSH re-pulses q_clear.
- A dispatch registered in the cycle before flush still presents dispatch_valid (the backend discards it). No dispatch_valid is generated after the FLUSH entry edge.
- Flush in IDLE with full credits: q_clear on the entry cycle, flush_done on the next cycle once flush=0.

Decomposition:
- Shared UOP package already provides uop_ins_t, uop_size_t, OUT_UOP, QU_UOP.
- Add to the package: dispatch_state_e enum {IDLE, DISPATCH, STALL, FLUSH}, and a credit_t typedef sized by CRED_W.
- One sub-module: uop_credit_counter, holding the credit add/subtract/clamp logic and the >=OUT_UOP / ==CREDITS flags. The FSM, output register and stall counter stay in the top module.

Test Plan:
- Reset, then q_elements=6, credit_ret=0, CREDITS=16, OUT_UOP=4 → expected:
  - get_uop high in cycles 1 and 2.
  - dispatch_cnt=4, then 2.
  - Credits 16→12→10.
- q_elements=3 (constant) with no credit_ret → issues n=3 per cycle, credits fall 16→13→10→7→4→1. The following cycle enters STALL, get_uop=0 and stall_cnt increments. credit_ret=3 in one cycle gives credits_next=4, returning to DISPATCH the next cycle.
- Same-cycle issue of 4 plus credit_ret=4 at credits=4 → credits stay at 4 and issue continues back-to-back.
- flush pulsed while DISPATCH with credits=8 → expected:
  - q_clear pulses once and get_uop is 0 that cycle.
  - Remains in FLUSH until credit_ret sums to 8.
  - flush_done pulses once, then state is IDLE.
- Reset asserted during FLUSH → all outputs return to reset values next cycle, credits=16, no flush_done.
- credit_ret overflow (credits=16, credit_ret=2) → credits stay 16 and the assertion fires.
